// File: rtl/dm_pkg.sv
// Shared definitions for the byte-addressable data memory.
//   sz_e encodings : SZ_BYTE, SZ_HALF, SZ_WORD (2'b11 is reserved/illegal)
//   dm_state_e     : CLEAR (post-reset zeroing) and READY (serving requests)
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dm_state_e;

endpackage

// File: rtl/dm_subword.sv
// Lane logic for sub-word accesses (purely combinational).
// Ports:
//   size     in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   addr_lo  in  2   byte offset inside the word
//   sext     in  1   sign-extend loads when 1
//   wdata    in  32  right-aligned store data
//   old_word in  32  current memory word at the addressed index
//   be       out 4   byte enables for a store
//   merged   out 32  old_word with the enabled lanes replaced by store data
//   load_val out 32  selected and extended load result
//   misalign out 1   half on an odd address or word not on a 4-byte boundary
module dm_subword
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [3:0]  be,
  output logic [31:0] merged,
  output logic [31:0] load_val,
  output logic        misalign
);

  logic [31:0] wrep;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Enables and lane replication: the store data is copied into every lane
  // so the enables alone decide which bytes change.
  always_comb begin
    be       = 4'b0000;
    wrep     = wdata;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        be   = 4'b0001 << addr_lo;
        wrep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{wdata[15:0]}};
        misalign = addr_lo[0];
      end
      SZ_WORD: begin
        be       = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wrep[8*i +: 8];
    end
  end

  assign lane_b = old_word[{addr_lo, 3'b000} +: 8];
  assign lane_h = addr_lo[1] ? old_word[31:16] : old_word[15:0];

  always_comb begin
    load_val = old_word;
    case (size)
      SZ_BYTE: load_val = {{24{sext & lane_b[7]}}, lane_b};
      SZ_HALF: load_val = {{16{sext & lane_h[15]}}, lane_h};
      default: load_val = old_word;
    endcase
  end

endmodule

// File: rtl/dm_bytemem.sv
// Data memory for the MEM stage: byte/half/word loads and stores, range and
// alignment exceptions, one-cycle registered responses, and a post-reset
// clear engine that zeroes every word before requests are accepted.
// Ports:
//   clk        in  1       rising-edge clock
//   reset      in  1       asynchronous active-low reset
//   req_valid  in  1       request present
//   req_ready  out 1       request accepted this cycle when high (READY state)
//   req_we     in  1       1 = store, 0 = load
//   req_size   in  2       00 byte, 01 half, 10 word, 11 reserved
//   req_sext   in  1       sign-extend loads
//   req_addr   in  ADDR_W  byte address
//   req_wdata  in  32      right-aligned store data
//   req_pc     in  32      issuing PC, trace only
//   resp_valid out 1       one-cycle response pulse
//   resp_rdata out 32      load result or merged store word (0 on exception)
//   resp_exc   out 1       request rejected
//   busy       out 1       clear engine running
//   state_dbg  out 1       current FSM state
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. Its response appears for exactly one cycle after
// that edge; there is no response back-pressure, so the consumer must take
// it then. resp_rdata/resp_exc hold between responses.
module dm_bytemem
  import dm_pkg::*;
#(
  parameter int DEPTH  = 3072,
  parameter int ADDR_W = 16,
  parameter int TRACE  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_exc,
  output logic              busy,
  output dm_state_e         state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [DEPTH];

  dm_state_e         state;
  logic [AW-1:0]     clr_idx;
  logic [ADDR_W-3:0] widx;
  logic [AW-1:0]     mem_idx;
  logic              in_range;
  logic              misalign;
  logic              illegal;
  logic              accept;
  logic [31:0]       old_word;
  logic [3:0]        be;
  logic [31:0]       merged;
  logic [31:0]       load_val;

  assign widx     = req_addr[ADDR_W-1:2];
  assign in_range = (32'(widx) < 32'(DEPTH));
  // Only meaningful when in_range; illegal requests never write.
  assign mem_idx  = AW'(widx);
  assign old_word = mem[mem_idx];
  assign accept   = req_valid && req_ready;
  assign illegal  = (req_size == 2'b11) || misalign || !in_range;

  dm_subword u_subword (
    .size     (req_size),
    .addr_lo  (req_addr[1:0]),
    .sext     (req_sext),
    .wdata    (req_wdata),
    .old_word (old_word),
    .be       (be),
    .merged   (merged),
    .load_val (load_val),
    .misalign (misalign)
  );

  // Array has no reset: the clear engine is what defines its contents.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= 32'h0;
    end else if (accept && req_we && !illegal && (be != 4'b0000)) begin
      mem[mem_idx] <= merged;
      if (TRACE != 0) begin
        $display("@%h: *%h <= %h", req_pc, 32'({widx, 2'b00}), merged);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      req_ready  <= 1'b0;
      busy       <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_exc   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          resp_valid <= 1'b0;
          if (clr_idx == AW'(DEPTH - 1)) begin
            state     <= READY;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            clr_idx <= clr_idx + AW'(1);
          end
        end
        READY: begin
          resp_valid <= accept;
          if (accept) begin
            resp_exc <= illegal;
            if (illegal)     resp_rdata <= 32'h0;
            else if (req_we) resp_rdata <= merged;
            else             resp_rdata <= load_val;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule
